// File: rtl/rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_ctrl_pkg
// Shared types, constants and helpers for the rx redundancy controller.
//   ctrl_state_e  : controller FSM states (RUN, WAIT_QUIET, APPLY)
//   RED_1/3/5     : legal redundancy (voter copy count) values
//   is_legal_red  : returns 1 for a legal redundancy value
//   next_red      : next escalation level (1->3, 3->5, saturates at 5)
// -----------------------------------------------------------------------------
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_QUIET = 2'd1,
        APPLY      = 2'd2
    } ctrl_state_e;

    localparam logic [7:0] RED_1 = 8'd1;
    localparam logic [7:0] RED_3 = 8'd3;
    localparam logic [7:0] RED_5 = 8'd5;

    function automatic logic is_legal_red(input logic [7:0] red);
        return (red == RED_1) || (red == RED_3) || (red == RED_5);
    endfunction

    function automatic logic [7:0] next_red(input logic [7:0] red);
        logic [7:0] nxt;
        case (red)
            RED_1:   nxt = RED_3;
            RED_3:   nxt = RED_5;
            default: nxt = RED_5;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rx_quiet_detector.sv
// -----------------------------------------------------------------------------
// rx_quiet_detector
// Counts consecutive idle cycles (rx_enable=0 and dp_en_out=0) while armed and
// raises quiet_done for one cycle once QUIET_CYCLES idle cycles have been seen.
// Any busy cycle restarts the count from zero.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   arm          : count only while high (controller is waiting for quiet)
//   rx_enable    : frame in progress from the rx front end
//   dp_en_out    : majority datapath still draining
//   quiet_done   : 1-cycle pulse, datapath has been idle long enough
// -----------------------------------------------------------------------------
module rx_quiet_detector #(
    parameter int QUIET_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic rx_enable,
    input  logic dp_en_out,
    output logic quiet_done
);

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES + 1) : 1;
    localparam logic [QW-1:0] LAST = QW'(QUIET_CYCLES - 1);

    logic [QW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // The counter value k means k idle cycles have already been seen; the
    // idle cycle observed while at LAST is the QUIET_CYCLES-th one. The pulse
    // is registered, and the counter is held at zero while disarmed or while
    // the pulse is out, so a late re-arm always starts a fresh count.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!arm || done_q) begin
            cnt_d = '0;
        end else if (rx_enable || dp_en_out) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
        end else begin
            cnt_d = cnt_q + QW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quiet_done = done_q;

endmodule

// File: rtl/rx_redundancy_ctrl.sv
// -----------------------------------------------------------------------------
// rx_redundancy_ctrl
// Schedules redundancy-mode changes for the rx majority-vote datapath.
// Host requests are validated, held pending, and applied only after the
// datapath has been quiet for QUIET_CYCLES cycles, so no frame is voted with
// mixed modes. Frame and loss statistics are kept alongside.
// Optional feature: define AUTO_ESCALATE_EN to raise the redundancy level
// automatically when too many loss events occur inside an observation window.
// Ports:
//   clk125MHz, reset_n       : clock, asynchronous active-low reset
//   cfg_redundancy/valid     : host mode request (legal 1/3/5)
//   cfg_ready                : request can be accepted (FSM in RUN)
//   cfg_err                  : 1-cycle pulse, illegal request rejected
//   rx_enable, dp_en_out     : datapath activity, used for quiet detection
//   dp_loss                  : loss indication from the datapath
//   redundancy               : mode driven to the majority datapath
//   switching                : mode change pending or being applied
//   mode_changed             : 1-cycle pulse when the new mode takes effect
//   auto_esc                 : 1-cycle pulse when an escalation is raised
//   frame_count, loss_count  : saturating rising-edge counters
// -----------------------------------------------------------------------------
module rx_redundancy_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int         QUIET_CYCLES = 16,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] DEFAULT_RED  = 8'd1,
    parameter int         ESC_WINDOW   = 1024,
    parameter int         ESC_THRESH   = 4
) (
    input  logic             clk125MHz,
    input  logic             reset_n,
    input  logic [7:0]       cfg_redundancy,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             rx_enable,
    input  logic             dp_en_out,
    input  logic             dp_loss,
    output logic [7:0]       redundancy,
    output logic             switching,
    output logic             mode_changed,
    output logic             auto_esc,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] loss_count
);

    ctrl_state_e      state_q, state_d;
    logic [7:0]       redundancy_q, redundancy_d;
    logic [7:0]       pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             mode_changed_q, mode_changed_d;
    logic             auto_esc_q, auto_esc_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] loss_count_q, loss_count_d;
    logic             rx_en_q;
    logic             dp_loss_q;

    logic             accept;
    logic             rx_rise;
    logic             loss_rise;
    logic             quiet_done;
    logic             esc_req;

    assign cfg_ready = (state_q == RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign rx_rise   = rx_enable && !rx_en_q;
    assign loss_rise = dp_loss && !dp_loss_q;

    rx_quiet_detector #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet (
        .clk        (clk125MHz),
        .rst_n      (reset_n),
        .arm        (state_q == WAIT_QUIET),
        .rx_enable  (rx_enable),
        .dp_en_out  (dp_en_out),
        .quiet_done (quiet_done)
    );

`ifdef AUTO_ESCALATE_EN
    localparam int WIN_W = (ESC_WINDOW > 1) ? $clog2(ESC_WINDOW) : 1;
    localparam int THR_W = $clog2(ESC_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ESC_WINDOW - 1);
    localparam logic [THR_W-1:0] THR      = THR_W'(ESC_THRESH);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [THR_W-1:0] win_loss_q, win_loss_d;

    // The window only advances in RUN. An escalation request restarts the
    // window whether it is taken or dropped in favour of a host accept, so a
    // dropped request is not re-raised on the very next cycle. The window
    // loss count saturates at the threshold, which at mode 5 simply parks it
    // until the window ends.
    always_comb begin
        win_cnt_d  = win_cnt_q;
        win_loss_d = win_loss_q;
        esc_req    = (state_q == RUN) && (win_loss_q == THR) && (redundancy_q < RED_5);
        if (state_q == APPLY || esc_req) begin
            win_cnt_d  = '0;
            win_loss_d = '0;
        end else if (state_q == RUN) begin
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d  = '0;
                win_loss_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                if (loss_rise && (win_loss_q != THR)) begin
                    win_loss_d = win_loss_q + THR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk125MHz or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q  <= '0;
            win_loss_q <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            win_loss_q <= win_loss_d;
        end
    end
`else
    logic esc_cfg_unused;

    assign esc_req        = 1'b0;
    assign esc_cfg_unused = (ESC_WINDOW != 0) ^ (ESC_THRESH != 0);
`endif

    // Main FSM. A host accept always wins over an escalation request in RUN.
    // An accepted request equal to the current mode is a no-op and never
    // leaves RUN. The mode, the mode_changed pulse and the loss counter clear
    // all take effect on the edge that ends the single APPLY cycle.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        redundancy_d   = redundancy_q;
        cfg_err_d      = 1'b0;
        mode_changed_d = 1'b0;
        auto_esc_d     = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (!is_legal_red(cfg_redundancy)) begin
                        cfg_err_d = 1'b1;
                    end else if (cfg_redundancy != redundancy_q) begin
                        pending_d = cfg_redundancy;
                        state_d   = WAIT_QUIET;
                    end
                end else if (esc_req) begin
                    pending_d  = next_red(redundancy_q);
                    auto_esc_d = 1'b1;
                    state_d    = WAIT_QUIET;
                end
            end
            WAIT_QUIET: begin
                if (quiet_done) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                redundancy_d   = pending_q;
                mode_changed_d = 1'b1;
                state_d        = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating statistics. The APPLY clear takes priority over a loss edge
    // seen in the same cycle, so that event is dropped rather than counted
    // against the new mode.
    always_comb begin
        frame_count_d = frame_count_q;
        loss_count_d  = loss_count_q;
        if (rx_rise && (frame_count_q != {CNT_W{1'b1}})) begin
            frame_count_d = frame_count_q + CNT_W'(1);
        end
        if (state_q == APPLY) begin
            loss_count_d = '0;
        end else if (loss_rise && (loss_count_q != {CNT_W{1'b1}})) begin
            loss_count_d = loss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk125MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            redundancy_q   <= DEFAULT_RED;
            pending_q      <= DEFAULT_RED;
            cfg_err_q      <= 1'b0;
            mode_changed_q <= 1'b0;
            auto_esc_q     <= 1'b0;
            frame_count_q  <= '0;
            loss_count_q   <= '0;
            rx_en_q        <= 1'b0;
            dp_loss_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            redundancy_q   <= redundancy_d;
            pending_q      <= pending_d;
            cfg_err_q      <= cfg_err_d;
            mode_changed_q <= mode_changed_d;
            auto_esc_q     <= auto_esc_d;
            frame_count_q  <= frame_count_d;
            loss_count_q   <= loss_count_d;
            rx_en_q        <= rx_enable;
            dp_loss_q      <= dp_loss;
        end
    end

    assign redundancy   = redundancy_q;
    assign switching    = (state_q != RUN);
    assign cfg_err      = cfg_err_q;
    assign mode_changed = mode_changed_q;
    assign auto_esc     = auto_esc_q;
    assign frame_count  = frame_count_q;
    assign loss_count   = loss_count_q;

endmodule

// File: tb/tb_rx_redundancy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_redundancy_ctrl
// Directed bench for rx_redundancy_ctrl. Stimulus pushes the expected pulse
// events (cycle and value) into queues; a monitor on the falling edge pops and
// compares whenever mode_changed, cfg_err or auto_esc is seen. CNT_W is reduced
// to 8 so counter saturation is reachable in a short run.
// The escalation section only runs when AUTO_ESCALATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_rx_redundancy_ctrl;

    localparam int QUIET = 16;
    localparam int CW    = 8;

    logic          clk125MHz = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    cfg_redundancy = 8'd0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          rx_enable = 1'b0;
    logic          dp_en_out = 1'b0;
    logic          dp_loss = 1'b0;
    logic [7:0]    redundancy;
    logic          switching;
    logic          mode_changed;
    logic          auto_esc;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] loss_count;

    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        int         cyc;
        logic [7:0] red;
    } modeExp_t;

    modeExp_t modeQ[$];
    int       errQ[$];
    int       escQ[$];

    rx_redundancy_ctrl #(
        .QUIET_CYCLES (QUIET),
        .CNT_W        (CW),
        .DEFAULT_RED  (8'd1),
        .ESC_WINDOW   (1024),
        .ESC_THRESH   (4)
    ) dut (
        .clk125MHz      (clk125MHz),
        .reset_n        (reset_n),
        .cfg_redundancy (cfg_redundancy),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_err        (cfg_err),
        .rx_enable      (rx_enable),
        .dp_en_out      (dp_en_out),
        .dp_loss        (dp_loss),
        .redundancy     (redundancy),
        .switching      (switching),
        .mode_changed   (mode_changed),
        .auto_esc       (auto_esc),
        .frame_count    (frame_count),
        .loss_count     (loss_count)
    );

    always #4 clk125MHz = ~clk125MHz;

    always @(posedge clk125MHz) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk125MHz);
        #1;
    endtask

    task automatic pushMode(input int c, input logic [7:0] r);
        modeExp_t e;
        e.cyc = c;
        e.red = r;
        modeQ.push_back(e);
    endtask

    // Presents one request and returns the cycle number of its accept edge.
    task automatic applyStimulus(input logic [7:0] val, output int acceptCyc);
        int n;
        n = 0;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("cfg_ready before request", cfg_ready, 1);
        cfg_redundancy = val;
        cfg_valid      = 1'b1;
        tick();
        acceptCyc = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic waitSettled(input string name, input int maxCycles);
        int n;
        n = 0;
        while ((modeQ.size() != 0 || errQ.size() != 0 || escQ.size() != 0) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput({name, " completes in time"}, (n < maxCycles), 1);
        tick();
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk125MHz) begin
        modeExp_t e;
        int       c;
        if (reset_n) begin
            if (mode_changed) begin
                if (modeQ.size() == 0) begin
                    checkOutput("unexpected mode_changed pulse", mode_changed, 0);
                end else begin
                    e = modeQ.pop_front();
                    checkOutput("mode_changed cycle", cyc, e.cyc);
                    checkOutput("redundancy at mode_changed", redundancy, e.red);
                    checkOutput("loss_count at mode_changed", loss_count, 0);
                end
            end
            if (cfg_err) begin
                if (errQ.size() == 0) begin
                    checkOutput("unexpected cfg_err pulse", cfg_err, 0);
                end else begin
                    c = errQ.pop_front();
                    checkOutput("cfg_err cycle", cyc, c);
                end
            end
            if (auto_esc) begin
                if (escQ.size() == 0) begin
                    checkOutput("unexpected auto_esc pulse", auto_esc, 0);
                end else begin
                    c = escQ.pop_front();
                    checkOutput("auto_esc cycle", cyc, c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a;
        int d;
        int b;
        int p;
        logic [7:0] badVals [4];
        badVals[0] = 8'd4;
        badVals[1] = 8'd0;
        badVals[2] = 8'd2;
        badVals[3] = 8'd255;

        // Reset state
        tick();
        tick();
        checkOutput("reset redundancy", redundancy, 1);
        checkOutput("reset cfg_ready", cfg_ready, 1);
        checkOutput("reset switching", switching, 0);
        checkOutput("reset frame_count", frame_count, 0);
        checkOutput("reset loss_count", loss_count, 0);
        checkOutput("reset cfg_err", cfg_err, 0);
        checkOutput("reset mode_changed", mode_changed, 0);
        checkOutput("reset auto_esc", auto_esc, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Illegal requests: cfg_err in the cycle after accept, nothing else moves
        foreach (badVals[i]) begin
            applyStimulus(badVals[i], a);
            errQ.push_back(a);
            waitSettled("illegal request", 10);
            checkOutput("redundancy after illegal", redundancy, 1);
            checkOutput("cfg_ready after illegal", cfg_ready, 1);
            checkOutput("switching after illegal", switching, 0);
        end

        // Same-mode request is a no-op
        applyStimulus(8'd1, a);
        tick();
        tick();
        checkOutput("switching after no-op 1", switching, 0);
        checkOutput("cfg_ready after no-op 1", cfg_ready, 1);

        // 1 -> 3 with idle datapath: applied QUIET+2 edges after accept
        applyStimulus(8'd3, a);
        pushMode(a + QUIET + 2, 8'd3);
        checkOutput("switching after accept", switching, 1);
        checkOutput("cfg_ready low after accept", cfg_ready, 0);
        tick();
        checkOutput("redundancy held while waiting", redundancy, 1);
        waitSettled("switch to 3", 100);
        checkOutput("redundancy after switch to 3", redundancy, 3);
        checkOutput("cfg_ready after switch to 3", cfg_ready, 1);

        // 3 -> 5 while a frame is in progress, with a dp_en_out blip in the wait
        rx_enable = 1'b1;
        applyStimulus(8'd5, a);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("switching while rx busy", switching, 1);
        end
        rx_enable = 1'b0;
        d = cyc;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("blip timing setup", cyc, d + 5);
        dp_en_out = 1'b1;
        b = cyc;
        pushMode(b + 1 + QUIET + 2, 8'd5);
        tick();
        dp_en_out = 1'b0;
        waitSettled("switch to 5", 100);
        checkOutput("redundancy after switch to 5", redundancy, 5);
        checkOutput("frame_count after one frame", frame_count, 1);

        // Loss counting, clear on apply, loss edge in APPLY not counted
        for (int i = 0; i < 3; i++) begin
            dp_loss = 1'b1;
            tick();
            dp_loss = 1'b0;
            tick();
        end
        tick();
        checkOutput("loss_count after 3 losses", loss_count, 3);
        applyStimulus(8'd3, a);
        pushMode(a + QUIET + 2, 8'd3);
        for (int i = 0; i < QUIET + 1; i++) tick();
        checkOutput("loss_count in APPLY cycle", loss_count, 3);
        checkOutput("switching in APPLY cycle", switching, 1);
        dp_loss = 1'b1;
        tick();
        dp_loss = 1'b0;
        tick();
        tick();
        checkOutput("loss edge in APPLY dropped", loss_count, 0);
        checkOutput("redundancy after switch back to 3", redundancy, 3);

        // No-op at 3
        applyStimulus(8'd3, a);
        tick();
        tick();
        checkOutput("switching after no-op 3", switching, 0);

        // frame_count saturation (CW=8): one frame already counted
        for (int i = 0; i < 253; i++) begin
            rx_enable = 1'b1;
            tick();
            rx_enable = 1'b0;
            tick();
        end
        checkOutput("frame_count at 254", frame_count, 254);
        for (int i = 0; i < 7; i++) begin
            rx_enable = 1'b1;
            tick();
            rx_enable = 1'b0;
            tick();
        end
        checkOutput("frame_count saturated", frame_count, 255);

        // Reset in the middle of a pending switch
        applyStimulus(8'd5, a);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("switching before mid reset", switching, 1);
        reset_n = 1'b0;
        #2;
        checkOutput("mid reset redundancy", redundancy, 1);
        checkOutput("mid reset cfg_ready", cfg_ready, 1);
        checkOutput("mid reset switching", switching, 0);
        checkOutput("mid reset frame_count", frame_count, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        checkOutput("no apply after reset", redundancy, 1);
        checkOutput("idle after reset", switching, 0);

`ifdef AUTO_ESCALATE_EN
        // Four losses inside the window at mode 1 escalate to 3
        p = 0;
        for (int i = 0; i < 4; i++) begin
            dp_loss = 1'b1;
            if (i == 3) p = cyc;
            tick();
            dp_loss = 1'b0;
            tick();
        end
        escQ.push_back(p + 2);
        pushMode(p + 2 + QUIET + 2, 8'd3);
        waitSettled("auto escalation", 100);
        checkOutput("redundancy after escalation", redundancy, 3);

        // At mode 5 losses raise nothing
        applyStimulus(8'd5, a);
        pushMode(a + QUIET + 2, 8'd5);
        waitSettled("host switch to 5", 100);
        for (int i = 0; i < 4; i++) begin
            dp_loss = 1'b1;
            tick();
            dp_loss = 1'b0;
            tick();
        end
        for (int i = 0; i < 30; i++) tick();
        checkOutput("no escalation at 5", redundancy, 5);
        checkOutput("no switching at 5", switching, 0);
`else
        p = 0;
        for (int i = 0; i < 4; i++) begin
            dp_loss = 1'b1;
            tick();
            dp_loss = 1'b0;
            tick();
        end
        for (int i = 0; i < 30; i++) tick();
        checkOutput("no escalation when disabled", redundancy, 1 + p);
        checkOutput("auto_esc tied low", auto_esc, 0);
`endif

        tick();
        checkOutput("mode queue drained", modeQ.size(), 0);
        checkOutput("err queue drained", errQ.size(), 0);
        checkOutput("esc queue drained", escQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
